// File: rtl/sparc_mem_pkg.sv
// Shared definitions for the SPARC memory responder: op3 encodings,
// FSM state type, access-size encoding and an opcode decode helper.
package sparc_mem_pkg;

  // SPARC op3 values for the supported loads and stores
  localparam logic [5:0] OP_LD   = 6'b000000;
  localparam logic [5:0] OP_LDUB = 6'b000001;
  localparam logic [5:0] OP_LDUH = 6'b000010;
  localparam logic [5:0] OP_LDSB = 6'b001001;
  localparam logic [5:0] OP_LDSH = 6'b001010;
  localparam logic [5:0] OP_ST   = 6'b000100;
  localparam logic [5:0] OP_STB  = 6'b000101;
  localparam logic [5:0] OP_STH  = 6'b000110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  typedef struct packed {
    logic  valid;
    logic  is_load;
    logic  is_signed;
    size_e size;
  } op_info_t;

  // Classify an op3 value; unknown codes come back with valid=0
  function automatic op_info_t decode_op(input logic [5:0] op3);
    op_info_t info;
    info = '{valid: 1'b1, is_load: 1'b1, is_signed: 1'b0, size: SZ_WORD};
    case (op3)
      OP_LD:   info.size = SZ_WORD;
      OP_LDUB: info.size = SZ_BYTE;
      OP_LDUH: info.size = SZ_HALF;
      OP_LDSB: begin info.size = SZ_BYTE; info.is_signed = 1'b1; end
      OP_LDSH: begin info.size = SZ_HALF; info.is_signed = 1'b1; end
      OP_ST:   begin info.size = SZ_WORD; info.is_load = 1'b0; end
      OP_STB:  begin info.size = SZ_BYTE; info.is_load = 1'b0; end
      OP_STH:  begin info.size = SZ_HALF; info.is_load = 1'b0; end
      default: info.valid = 1'b0;
    endcase
    return info;
  endfunction

  // Lane i holds the byte at offset i from the access address
  function automatic logic [3:0] lane_mask(input size_e sz);
    case (sz)
      SZ_BYTE: return 4'b0001;
      SZ_HALF: return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/mem_byte_array.sv
// Byte-addressed storage, DEPTH x 8. Four byte lanes starting at addr_i
// (lane 0 = addr_i, lane 3 = addr_i+3, wrapping modulo DEPTH), presented
// big-endian on the 32-bit buses. Read is combinational, write per lane.
module mem_byte_array #(
  parameter int DEPTH = 512
) (
  input  logic                     clk,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [3:0]               we_i,
  input  logic [31:0]              wdata_i,
  output logic [31:0]              rdata_o
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0] mem_q [DEPTH];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [AW-1:0] lane_addr;
      assign lane_addr                 = addr_i + AW'(gi);
      assign rdata_o[31-8*gi -: 8]     = mem_q[lane_addr];
    end
  endgenerate

  // Write each enabled lane to its own (wrapped) byte address
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we_i[i]) begin
        mem_q[addr_i + AW'(i)] <= wdata_i[31-8*i -: 8];
      end
    end
  end

endmodule

// File: rtl/memory_responder.sv
// Memory responder for a SPARC-style control unit: accepts a load/store
// request, waits WAIT_CYCLES edges, performs the access and raises MFC
// until the request strobe drops.
// Optional build macro: MEMORY_RESPONDER_ALIGN_CHECK_EN rejects misaligned
// halfword/word accesses with Fault instead of wrapping them.
module memory_responder
  import sparc_mem_pkg::*;
#(
  parameter int DEPTH       = 512,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        Clr,
  input  logic        RAM_enable,
  input  logic [5:0]  RAM_OpCode,
  input  logic [31:0] Address,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
  output logic        MFC,
  output logic        Fault
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [31:0] ADDR_MASK = 32'(DEPTH - 1);
  localparam logic [3:0]  WAIT_LAST = 4'(WAIT_CYCLES);

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [5:0]  op_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic [31:0] dout_q;
  logic        mfc_q;
  logic        fault_q;

  logic [5:0]  eff_op;
  logic [31:0] eff_addr;
  logic [31:0] eff_data;
  op_info_t    info;
  logic        misalign;
  logic        access_fault;
  logic        complete;
  logic [3:0]  we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [31:0] load_val;

  mem_byte_array #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (Clk),
    .addr_i  (eff_addr[AW-1:0]),
    .we_i    (we),
    .wdata_i (wdata),
    .rdata_o (rdata)
  );

  // Decode the access; in IDLE the live inputs are used so a zero-wait
  // request completes on its accept edge, otherwise the latched copy.
  always_comb begin
    eff_op   = (state_q == IDLE) ? RAM_OpCode : op_q;
    eff_addr = (state_q == IDLE) ? Address    : addr_q;
    eff_data = (state_q == IDLE) ? DataIn     : data_q;
    info     = decode_op(eff_op);

    misalign = 1'b0;
`ifdef MEMORY_RESPONDER_ALIGN_CHECK_EN
    if (info.size == SZ_HALF) begin
      misalign = eff_addr[0];
    end else if (info.size == SZ_WORD) begin
      misalign = |eff_addr[1:0];
    end
`endif

    access_fault = !info.valid || (|(eff_addr & ~ADDR_MASK)) || misalign;

    // The DONE-entry edge; never while reset is asserted
    complete = Clr && (((state_q == IDLE) && RAM_enable && (WAIT_CYCLES == 0)) ||
                       ((state_q == BUSY) && (cnt_q == WAIT_LAST)));

    we = (complete && !access_fault && !info.is_load) ? lane_mask(info.size) : 4'b0000;

    // Left-justify store data so lane 0 carries the most significant stored byte
    case (info.size)
      SZ_BYTE: wdata = {eff_data[7:0], 24'h0};
      SZ_HALF: wdata = {eff_data[15:0], 16'h0};
      default: wdata = eff_data;
    endcase

    case (info.size)
      SZ_BYTE: load_val = {{24{info.is_signed & rdata[31]}}, rdata[31:24]};
      SZ_HALF: load_val = {{16{info.is_signed & rdata[31]}}, rdata[31:16]};
      default: load_val = rdata;
    endcase
  end

  // Request FSM with registered MFC/Fault/DataOut
  always_ff @(posedge Clk) begin
    if (!Clr) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      mfc_q   <= 1'b0;
      fault_q <= 1'b0;
      dout_q  <= 32'h0;
    end else begin
      case (state_q)
        IDLE: begin
          if (RAM_enable) begin
            op_q   <= RAM_OpCode;
            addr_q <= Address;
            data_q <= DataIn;
            cnt_q  <= 4'd1;
            if (complete) begin
              state_q <= DONE;
              mfc_q   <= 1'b1;
              fault_q <= access_fault;
            end else begin
              state_q <= BUSY;
            end
          end
        end
        BUSY: begin
          if (complete) begin
            state_q <= DONE;
            mfc_q   <= 1'b1;
            fault_q <= access_fault;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        DONE: begin
          if (!RAM_enable) begin
            state_q <= IDLE;
            mfc_q   <= 1'b0;
            fault_q <= 1'b0;
            cnt_q   <= 4'd0;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (complete && !access_fault && info.is_load) begin
        dout_q <= load_val;
      end
    end
  end

  assign DataOut = dout_q;
  assign MFC     = mfc_q;
  assign Fault   = fault_q;

endmodule
